// File: rtl/hazard_control_unit_pkg.sv
// Shared CPU pipeline definitions: hazard FSM state encoding and register constants.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package hazard_control_unit_pkg;

  // Hazard controller states; the encoding is fixed so other pipeline blocks can decode it.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REPLAY   = 2'd2
  } hcu_state_t;

  // x0 is hardwired to zero; writes to it are discarded, so it never carries a dependency.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Load-use dependency: the load in EX produces a register that the ID instruction reads.
  function automatic logic load_use(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       use_rs1,
    input logic [4:0] rs2,
    input logic       use_rs2
  );
    return mem_read && (rd != REG_X0) &&
           ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Latency: count updates one clock after en/clr are sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
//
// Ports: clk, clr (sync clear, wins over en), en (count this cycle), count (CNT_W-bit value).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory wait with deferred flush replay.
// Latency: control outputs are combinational from registered state and current inputs; state/counter update at clk.
// Backpressure: dmem_busy freezes PC, IF/ID and EX/MEM/WB; a branch seen during the wait is replayed as a flush afterwards.
//
// Ports: clk, rst (sync, active-high); ID operands id_rs1/id_rs2 with id_use_rs1/id_use_rs2;
//        EX info idex_rd, idex_mem_read, ex_branch_taken; dmem_busy from data memory;
//        outputs pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, stall_count.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic [CNT_W-1:0] stall_count
);

  hcu_state_t state, state_nxt;
  logic       pending_flush, pending_nxt;
  logic       lu;

  assign lu = load_use(idex_mem_read, idex_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    state_nxt   = ST_RUN;
    pending_nxt = 1'b0;

    if (rst) begin
      // Front end parked with NOPs while in reset.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (dmem_busy) begin
      // Freeze the whole pipe; remember any branch so its flush happens once memory frees up.
      // In RUN pending_flush is always clear, so OR-ing covers both "sample" and "accumulate".
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      exmem_hold  = 1'b1;
      state_nxt   = ST_MEM_WAIT;
      pending_nxt = pending_flush | ex_branch_taken;
    end else if (state == ST_REPLAY) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (ex_branch_taken || pending_flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      // Leaving a wait that swallowed a branch: follow up with one replay flush cycle.
      if ((state == ST_MEM_WAIT) && pending_flush) begin
        state_nxt   = ST_REPLAY;
        pending_nxt = 1'b1;
      end
    end else if (lu) begin
      // One bubble per load: next cycle the load has left EX, so the hazard clears itself.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RUN;
      pending_flush <= 1'b0;
    end else begin
      state         <= state_nxt;
      pending_flush <= pending_nxt;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (~pc_write & ~rst),
    .count (stall_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, idex_rd;
  logic             id_use_rs1, id_use_rs2, idex_mem_read, ex_branch_taken, dmem_busy;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold;
  logic [CNT_W-1:0] stall_count;
  logic [4:0]       obs;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: "waiting" / "replaying" flags, deferred-flush flag, integer stall tally.
  bit m_wait, m_replay, m_pend;
  int m_cnt;

  hazard_control_unit #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .idex_rd         (idex_rd),
    .idex_mem_read   (idex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .dmem_busy       (dmem_busy),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .exmem_hold      (exmem_hold),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}
  assign obs = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold};

  localparam logic [4:0] O_RESET = 5'b00110;
  localparam logic [4:0] O_HOLD  = 5'b00001;
  localparam logic [4:0] O_FLUSH = 5'b11110;
  localparam logic [4:0] O_LU    = 5'b00010;
  localparam logic [4:0] O_NORM  = 5'b11000;

  function automatic bit m_lu();
    if (!idex_mem_read || idex_rd == 5'd0) return 1'b0;
    return (id_use_rs1 && id_rs1 == idex_rd) || (id_use_rs2 && id_rs2 == idex_rd);
  endfunction

  function automatic logic [4:0] m_outs();
    if (rst)                     return O_RESET;
    if (dmem_busy)               return O_HOLD;
    if (m_replay)                return O_FLUSH;
    if (ex_branch_taken || m_pend) return O_FLUSH;
    if (m_lu())                  return O_LU;
    return O_NORM;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void model_step();
    logic [4:0] o;
    o = m_outs();
    if (rst) begin
      m_wait = 0; m_replay = 0; m_pend = 0; m_cnt = 0;
      return;
    end
    if (!o[4] && m_cnt < CNT_MAX) m_cnt++;
    if (dmem_busy) begin
      m_pend   = m_pend || ex_branch_taken;
      m_wait   = 1;
      m_replay = 0;
    end else if (m_replay) begin
      m_replay = 0;
      m_pend   = 0;
    end else if (m_wait) begin
      m_wait   = 0;
      m_replay = m_pend;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    idex_rd = 0; idex_mem_read = 0; ex_branch_taken = 0; dmem_busy = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    @(negedge clk);
    total_cnt++;
    if (obs !== O_RESET) $display("FAIL reset_outs: got %b want %b", obs, O_RESET); else pass_cnt++;
    total_cnt++;
    if (stall_count !== 0) $display("FAIL reset_count: got %0d want 0", stall_count); else pass_cnt++;
    rst = 0; dmem_busy = 1;
    tick(); tick();
    rst = 1;
    @(negedge clk);
    total_cnt++;
    if (obs !== O_RESET) $display("FAIL reset_over_busy: got %b want %b", obs, O_RESET); else pass_cnt++;
    tick(); tick();
    @(negedge clk);
    total_cnt++;
    if (stall_count !== 0) $display("FAIL reset_no_count: got %0d want 0", stall_count); else pass_cnt++;
    rst = 0; dmem_busy = 0;
  endtask

  task automatic test_load_use();
    do_reset();
    idex_rd = 5; idex_mem_read = 1; id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 7; id_use_rs2 = 1;
    @(negedge clk);
    total_cnt++;
    if (obs !== O_LU) $display("FAIL lu_stall: got %b want %b", obs, O_LU); else pass_cnt++;
    tick();
    idex_rd = 0; idex_mem_read = 0;  // bubble now in EX
    @(negedge clk);
    total_cnt++;
    if (obs !== O_NORM) $display("FAIL lu_resume: got %b want %b", obs, O_NORM); else pass_cnt++;
    total_cnt++;
    if (stall_count !== 1) $display("FAIL lu_count: got %0d want 1", stall_count); else pass_cnt++;
    // rs2 path, rs1 unused even though it matches
    idex_rd = 9; idex_mem_read = 1; id_rs1 = 9; id_use_rs1 = 0; id_rs2 = 9; id_use_rs2 = 1;
    @(negedge clk);
    total_cnt++;
    if (obs !== O_LU) $display("FAIL lu_rs2: got %b want %b", obs, O_LU); else pass_cnt++;
    id_use_rs2 = 0;
    @(negedge clk);
    total_cnt++;
    if (obs !== O_NORM) $display("FAIL lu_unused: got %b want %b", obs, O_NORM); else pass_cnt++;
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    idex_rd = 0; idex_mem_read = 1; id_rs1 = 0; id_use_rs1 = 1; id_rs2 = 0; id_use_rs2 = 1;
    @(negedge clk);
    total_cnt++;
    if (obs !== O_NORM) $display("FAIL x0_no_stall: got %b want %b", obs, O_NORM); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if (stall_count !== 0) $display("FAIL x0_count: got %0d want 0", stall_count); else pass_cnt++;
  endtask

  task automatic test_branch_lu();
    do_reset();
    idex_rd = 3; idex_mem_read = 1; id_rs1 = 3; id_use_rs1 = 1; ex_branch_taken = 1;
    @(negedge clk);
    total_cnt++;
    if (obs !== O_FLUSH) $display("FAIL branch_over_lu: got %b want %b", obs, O_FLUSH); else pass_cnt++;
    tick();
    idle_inputs();
    @(negedge clk);
    total_cnt++;
    if (stall_count !== 0) $display("FAIL branch_count: got %0d want 0", stall_count); else pass_cnt++;
  endtask

  task automatic test_mem_wait_replay();
    logic [4:0] want [6];
    want = '{O_HOLD, O_HOLD, O_HOLD, O_FLUSH, O_FLUSH, O_NORM};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      dmem_busy       = (c < 3);
      ex_branch_taken = (c == 1);
      @(negedge clk);
      total_cnt++;
      if (obs !== want[c]) $display("FAIL memwait_c%0d: got %b want %b", c, obs, want[c]); else pass_cnt++;
      tick();
    end
    ex_branch_taken = 0;
    @(negedge clk);
    total_cnt++;
    if (stall_count !== 3) $display("FAIL memwait_count: got %0d want 3", stall_count); else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_reset();
    dmem_busy = 1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 14 || c == 15 || c == 20) begin
        @(negedge clk);
        total_cnt++;
        if (stall_count !== CNT_W'((c < CNT_MAX) ? c : CNT_MAX))
          $display("FAIL sat_after_%0d: got %0d want %0d", c, stall_count, (c < CNT_MAX) ? c : CNT_MAX);
        else pass_cnt++;
      end
    end
    dmem_busy = 0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    dmem_busy = 1; ex_branch_taken = 1;
    tick();
    ex_branch_taken = 0;
    tick();
    dmem_busy = 0; rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    total_cnt++;
    if (obs !== O_NORM) $display("FAIL rstwait_no_flush: got %b want %b", obs, O_NORM); else pass_cnt++;
    total_cnt++;
    if (stall_count !== 0) $display("FAIL rstwait_count: got %0d want 0", stall_count); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if (obs !== O_NORM) $display("FAIL rstwait_no_replay: got %b want %b", obs, O_NORM); else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst             = ($urandom_range(0, 49) == 0);
      dmem_busy       = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      idex_mem_read   = $urandom_range(0, 1);
      idex_rd         = 5'($urandom_range(0, 3));
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_use_rs1      = $urandom_range(0, 1);
      id_use_rs2      = $urandom_range(0, 1);
      @(negedge clk);
      total_cnt++;
      if (obs !== m_outs()) $display("FAIL rand_outs_%0d: got %b want %b", c, obs, m_outs()); else pass_cnt++;
      total_cnt++;
      if (stall_count !== CNT_W'(m_cnt)) $display("FAIL rand_count_%0d: got %0d want %0d", c, stall_count, m_cnt);
      else pass_cnt++;
      tick();
    end
    rst = 0;
  endtask

  initial begin
    m_wait = 0; m_replay = 0; m_pend = 0; m_cnt = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_x0();
    test_branch_lu();
    test_mem_wait_replay();
    test_saturation();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter: CNT_W, default 16, stall-counter width in bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-005 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
REQ-006 idex_rd  in  5  destination register of the instruction in EX.
REQ-007 idex_mem_read  in  1  EX instruction is a load.
REQ-008 ex_branch_taken  in  1  EX resolves a taken branch or jump this cycle.
REQ-009 dmem_busy  in  1  data memory not ready; the MEM access must be held.
REQ-010 pc_write  out  1  PC register load enable.
REQ-011 ifid_write  out  1  IF/ID register load enable.
REQ-012 ifid_flush  out  1  load NOP into IF/ID.
REQ-013 idex_bubble  out  1  load NOP (all control bits 0) into ID/EX.
REQ-014 exmem_hold  out  1  hold EX/MEM and MEM/WB contents.
REQ-015 stall_count  out  CNT_W  saturating count of cycles with pc_write=0.

Function
REQ-016 Outputs are combinational from registered state plus current inputs; state and counter are registered.
REQ-017 Load-use hazard (LU): idex_mem_read=1, idex_rd!=0, and (id_use_rs1 and id_rs1==idex_rd, or id_use_rs2 and id_rs2==idex_rd).
REQ-018 States: RUN, MEM_WAIT, REPLAY.
REQ-019 Priority within a cycle: dmem_busy > branch (ex_branch_taken or pending flush) > LU > normal.
REQ-020 RUN, dmem_busy=1: pc_write=0, ifid_write=0, exmem_hold=1, idex_bubble=0, ifid_flush=0; next state MEM_WAIT; ex_branch_taken sampled into pending_flush.
REQ-021 RUN, branch without busy: pc_write=1, ifid_flush=1, idex_bubble=1, ifid_write=1; stay RUN.
REQ-022 RUN, LU without busy/branch: pc_write=0, ifid_write=0, idex_bubble=1; stay RUN; exactly one stall cycle per load.
REQ-023 RUN, normal: pc_write=1, ifid_write=1, all other outputs 0.
REQ-024 MEM_WAIT, dmem_busy=1: same outputs as REQ-020; ex_branch_taken ORed into pending_flush.
REQ-025 MEM_WAIT, dmem_busy=0: pending_flush=1 -> REPLAY, else RUN; outputs this cycle per RUN rules (REQ-021..023).
REQ-026 REPLAY: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1; pending_flush cleared; next RUN; if dmem_busy=1 in REPLAY, REQ-020 applies and pending_flush stays set.
REQ-027 stall_count increments each cycle pc_write=0; saturates at 2^CNT_W-1, no wrap.
REQ-028 idex_rd==0 never raises LU (x0 writes discarded).

Reset
REQ-029 rst=1 at a rising edge: state RUN, pending_flush 0, stall_count 0.
REQ-030 While rst=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_hold=0; stall_count does not increment.
REQ-031 rst asserted in MEM_WAIT or REPLAY abandons the wait/replay; no pending flush survives reset.

Structure
REQ-032 Shared CPU package holds the state encoding (RUN=0, MEM_WAIT=1, REPLAY=2, 2 bits) and the x0 register index constant.
REQ-033 One sub-module natural: sat_counter (CNT_W-bit saturating counter, enable, sync clear).

Verification
REQ-034 lw x5 in EX (idex_rd=5, mem_read=1), ID reads rs1=5 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle normal; stall_count=1.
REQ-035 Same as REQ-034 with idex_rd=0 -> no stall, stall_count=0.
REQ-036 ex_branch_taken=1 and LU same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1; stall_count unchanged.
REQ-037 dmem_busy high 3 cycles, ex_branch_taken pulsed in 2nd -> 3 cycles exmem_hold=1, pc_write=0; then one REPLAY cycle with ifid_flush=1; stall_count=3.
REQ-038 CNT_W=4, 20 consecutive busy cycles -> stall_count stops at 15.
REQ-039 rst pulsed mid-MEM_WAIT with pending flush -> after release state RUN, no replay flush, stall_count=0.
